// File: rtl/rf_lane_2r1w_clr.sv
// rf_lane_2r1w_clr: 2-read/1-write register file with lane write enables and a hardware clear engine
// Ports:
//   clk, reset (async active-low), clear_req       - clock, reset, full-clear request
//   ready                                          - clear done; writes accepted, reads valid
//   read_addr0/1 -> read_data0/1                   - combinational read ports (0 unless ready)
//   write_lane_en, write_addr, write_data          - lane-granular write port
// Optional: define RF_LANE_BYPASS_EN to forward same-cycle write lanes to matching read ports.
module rf_lane_2r1w_clr #(
  parameter int NBITS = 8,
  parameter int NENTRIES = 8,
  parameter int LANE_BITS = 4,
  localparam int NLANES = NBITS / LANE_BITS,
  localparam int AW = $clog2(NENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              ready,
  input  logic [AW-1:0]     read_addr0,
  output logic [NBITS-1:0]  read_data0,
  input  logic [AW-1:0]     read_addr1,
  output logic [NBITS-1:0]  read_data1,
  input  logic [NLANES-1:0] write_lane_en,
  input  logic [AW-1:0]     write_addr,
  input  logic [NBITS-1:0]  write_data
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state;
  logic [AW-1:0] clr_addr;
  logic [NBITS-1:0] mem [NENTRIES];
  logic [1:0][AW-1:0] raddr;
  function automatic logic in_range(input logic [AW-1:0] a);
    return (AW+1)'(a) <= (AW+1)'(NENTRIES - 1);
  endfunction
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= CLEAR;
      clr_addr <= '0;
      ready <= 1'b0;
    end else if (state == CLEAR) begin
      if (clr_addr == AW'(NENTRIES - 1)) begin
        state <= READY;
        ready <= 1'b1;
        clr_addr <= '0;
      end else begin
        clr_addr <= clr_addr + 1'b1;
      end
    end else if (clear_req) begin
      state <= CLEAR;
      ready <= 1'b0;
      clr_addr <= '0;
    end
  // Storage has no reset; it is zeroed one entry per edge by the clear engine instead.
  always_ff @(posedge clk)
    if (reset) begin
      if (state == CLEAR)
        mem[clr_addr] <= '0;
      else if (!clear_req && in_range(write_addr))
        for (int i = 0; i < NLANES; i++)
          if (write_lane_en[i])
            mem[write_addr][i*LANE_BITS +: LANE_BITS] <= write_data[i*LANE_BITS +: LANE_BITS];
    end
  assign raddr = {read_addr1, read_addr0};
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [NBITS-1:0] d;
    always_comb begin
      d = '0;
      if (ready && in_range(raddr[p])) begin
        d = mem[raddr[p]];
`ifdef RF_LANE_BYPASS_EN
        if (!clear_req && raddr[p] == write_addr)
          for (int i = 0; i < NLANES; i++)
            if (write_lane_en[i])
              d[i*LANE_BITS +: LANE_BITS] = write_data[i*LANE_BITS +: LANE_BITS];
`endif
      end
    end
  end
  assign read_data0 = g_rd[0].d;
  assign read_data1 = g_rd[1].d;
endmodule

// File: tb/tb_rf_lane_2r1w_clr.sv
// tb_rf_lane_2r1w_clr: directed self-checking bench for rf_lane_2r1w_clr (8-entry and 6-entry instances)
module tb_rf_lane_2r1w_clr;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear_req = 1'b0;
  logic ready;
  logic [2:0] read_addr0 = '0, read_addr1 = '0, write_addr = '0;
  logic [7:0] read_data0, read_data1, write_data = '0;
  logic [1:0] write_lane_en = '0;
  logic ready6;
  logic [2:0] r6_addr0 = '0, r6_addr1 = '0, w6_addr = '0;
  logic [7:0] r6_data0, r6_data1, w6_data = '0;
  logic [1:0] w6_en = '0;
  int passed = 0;
  int total = 0;

  rf_lane_2r1w_clr dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready),
    .read_addr0(read_addr0), .read_data0(read_data0),
    .read_addr1(read_addr1), .read_data1(read_data1),
    .write_lane_en(write_lane_en), .write_addr(write_addr), .write_data(write_data)
  );

  rf_lane_2r1w_clr #(.NENTRIES(6)) dut6 (
    .clk(clk), .reset(reset), .clear_req(1'b0), .ready(ready6),
    .read_addr0(r6_addr0), .read_data0(r6_data0),
    .read_addr1(r6_addr1), .read_data1(r6_data1),
    .write_lane_en(w6_en), .write_addr(w6_addr), .write_data(w6_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic [1:0] en);
    write_addr = a;
    write_data = d;
    write_lane_en = en;
    tick();
    write_lane_en = '0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    total++;
    if (ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", ready); else passed++;
    total++;
    if (read_data0 !== 8'h00) $display("FAIL reset_rd0 got %h exp 00", read_data0); else passed++;
    tick();
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (ready !== (k == 8)) $display("FAIL ready_edge%0d got %b exp %b", k, ready, k == 8); else passed++;
      if (k == 6 || k == 5) begin
        total++;
        if (ready6 !== (k == 6)) $display("FAIL ready6_edge%0d got %b exp %b", k, ready6, k == 6); else passed++;
      end
    end
    for (int a = 0; a < 8; a++) begin
      read_addr0 = 3'(a);
      read_addr1 = 3'(7 - a);
      #1;
      total++;
      if (read_data0 !== 8'h00 || read_data1 !== 8'h00)
        $display("FAIL init_zero addr%0d got %h/%h exp 00/00", a, read_data0, read_data1);
      else passed++;
    end
  endtask

  task automatic test_lanes();
    read_addr0 = 3'd3;
    read_addr1 = 3'd3;
    wr(3'd3, 8'hff, 2'b11);
    total++;
    if (read_data0 !== 8'hff) $display("FAIL lane_full got %h exp ff", read_data0); else passed++;
    wr(3'd3, 8'hab, 2'b01);
    total++;
    if (read_data0 !== 8'hfb) $display("FAIL lane_lo got %h exp fb", read_data0); else passed++;
    wr(3'd3, 8'h5c, 2'b10);
    total++;
    if (read_data1 !== 8'h5b) $display("FAIL lane_hi got %h exp 5b", read_data1); else passed++;
    wr(3'd3, 8'h00, 2'b00);
    total++;
    if (read_data0 !== 8'h5b) $display("FAIL lane_none got %h exp 5b", read_data0); else passed++;
  endtask

  task automatic test_same_cycle();
    logic [7:0] now_exp, next_exp;
    logic [1:0] en;
`ifdef RF_LANE_BYPASS_EN
    en = 2'b10; now_exp = 8'hc0; next_exp = 8'hc0;
`else
    en = 2'b11; now_exp = 8'h00; next_exp = 8'hcd;
`endif
    read_addr0 = 3'd2;
    read_addr1 = 3'd2;
    write_addr = 3'd2;
    write_data = 8'hcd;
    write_lane_en = en;
    #1;
    total++;
    if (read_data0 !== now_exp || read_data1 !== now_exp)
      $display("FAIL same_cycle got %h/%h exp %h", read_data0, read_data1, now_exp);
    else passed++;
    tick();
    write_lane_en = '0;
    total++;
    if (read_data0 !== next_exp || read_data1 !== next_exp)
      $display("FAIL next_cycle got %h/%h exp %h", read_data0, read_data1, next_exp);
    else passed++;
  endtask

  task automatic test_oob();
    wr(3'd0, 8'h00, 2'b00);
    w6_addr = 3'd5; w6_data = 8'h3c; w6_en = 2'b11;
    tick();
    w6_addr = 3'd7; w6_data = 8'h12;
    tick();
    w6_en = '0;
    r6_addr0 = 3'd7;
    r6_addr1 = 3'd5;
    #1;
    total++;
    if (r6_data0 !== 8'h00) $display("FAIL oob_read got %h exp 00", r6_data0); else passed++;
    total++;
    if (r6_data1 !== 8'h3c) $display("FAIL oob_keep5 got %h exp 3c", r6_data1); else passed++;
  endtask

  task automatic test_clear_req();
    for (int a = 0; a < 8; a++) wr(3'(a), 8'(8'h11 * (a + 1)), 2'b11);
    read_addr0 = 3'd7;
    read_addr1 = 3'd0;
    #1;
    total++;
    if (read_data0 !== 8'h88 || read_data1 !== 8'h11)
      $display("FAIL filled got %h/%h exp 88/11", read_data0, read_data1);
    else passed++;
    clear_req = 1'b1;
    wr(3'd0, 8'h77, 2'b11);
    clear_req = 1'b0;
    total++;
    if (ready !== 1'b0 || read_data0 !== 8'h00)
      $display("FAIL clr_enter got ready=%b rd=%h exp 0/00", ready, read_data0);
    else passed++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (ready !== (k == 8)) $display("FAIL clr_edge%0d got %b exp %b", k, ready, k == 8); else passed++;
    end
    for (int a = 0; a < 8; a++) begin
      read_addr0 = 3'(a);
      read_addr1 = 3'(a);
      #1;
      total++;
      if (read_data0 !== 8'h00 || read_data1 !== 8'h00)
        $display("FAIL cleared addr%0d got %h/%h exp 00", a, read_data0, read_data1);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_clear();
    wr(3'd1, 8'h99, 2'b11);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (ready !== 1'b0) $display("FAIL midreset_ready got %b exp 0", ready); else passed++;
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (ready !== (k == 8)) $display("FAIL rerun_edge%0d got %b exp %b", k, ready, k == 8); else passed++;
    end
    read_addr0 = 3'd1;
    #1;
    total++;
    if (read_data0 !== 8'h00) $display("FAIL rerun_zero got %h exp 00", read_data0); else passed++;
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_same_cycle();
    test_oob();
    test_clear_req();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
